// File: rtl/seven_seg_pkg.sv
// Shared segment encodings for the 7-segment scan controller.
// Segment bus order is {a,b,c,d,e,f,g} with segment a in bit 6.
package seven_seg_pkg;

    localparam int SEG_A_BIT = 6;
    localparam int SEG_B_BIT = 5;
    localparam int SEG_C_BIT = 4;
    localparam int SEG_D_BIT = 3;
    localparam int SEG_E_BIT = 2;
    localparam int SEG_F_BIT = 1;
    localparam int SEG_G_BIT = 0;

    localparam logic [6:0] SEG_A = 7'(1 << SEG_A_BIT);
    localparam logic [6:0] SEG_B = 7'(1 << SEG_B_BIT);
    localparam logic [6:0] SEG_C = 7'(1 << SEG_C_BIT);
    localparam logic [6:0] SEG_D = 7'(1 << SEG_D_BIT);
    localparam logic [6:0] SEG_E = 7'(1 << SEG_E_BIT);
    localparam logic [6:0] SEG_F = 7'(1 << SEG_F_BIT);
    localparam logic [6:0] SEG_G = 7'(1 << SEG_G_BIT);

    localparam logic [6:0] SEG_0     = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F;
    localparam logic [6:0] SEG_1     = SEG_B | SEG_C;
    localparam logic [6:0] SEG_2     = SEG_A | SEG_B | SEG_D | SEG_E | SEG_G;
    localparam logic [6:0] SEG_3     = SEG_A | SEG_B | SEG_C | SEG_D | SEG_G;
    localparam logic [6:0] SEG_4     = SEG_B | SEG_C | SEG_F | SEG_G;
    localparam logic [6:0] SEG_5     = SEG_A | SEG_C | SEG_D | SEG_F | SEG_G;
    localparam logic [6:0] SEG_6     = SEG_A | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
    localparam logic [6:0] SEG_7     = SEG_A | SEG_B | SEG_C;
    localparam logic [6:0] SEG_8     = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
    localparam logic [6:0] SEG_9     = SEG_A | SEG_B | SEG_C | SEG_D | SEG_F | SEG_G;
    localparam logic [6:0] SEG_BLANK = 7'b000_0000;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_SHOW  = 1'b1
    } slot_phase_e;

endpackage

// File: rtl/seven_seg_scan_ctrl_bcd_to_seg.sv
// Combinational BCD-to-7-segment decoder; non-decimal codes produce a dark digit.
module bcd_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multi-digit 7-segment scan controller: double-buffered BCD load, one-hot
// digit rotation with a leading blank interval per slot, registered outputs.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    blank_lz,
    output logic                    ready,
    output logic [6:0]              segment,
    output logic [NUM_DIGITS-1:0]   digit_en
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
    logic                    pend_valid_q, pend_valid_d;
    logic                    ready_q, ready_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   en_q, en_d;

    logic [3:0]            nib [NUM_DIGITS];
    logic [NUM_DIGITS:0]   zero_above;
    logic [NUM_DIGITS-1:0] lz_vec;
    logic [3:0]            cur_nib;
    logic [6:0]            dec_seg;
    logic                  lz_blank;
    logic                  frame_end;
    slot_phase_e           phase;

    // zero_above[i]: nibble i and every more significant nibble are zero.
    assign zero_above[NUM_DIGITS] = 1'b1;
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign nib[gi]        = disp_q[gi*4 +: 4];
            assign zero_above[gi] = (disp_q[gi*4 +: 4] == 4'd0) && zero_above[gi+1];
            assign lz_vec[gi]     = zero_above[gi];
        end
    endgenerate

    assign cur_nib   = nib[idx_q];
    assign lz_blank  = blank_lz && (idx_q != '0) && lz_vec[idx_q];
    assign frame_end = (idx_q == IDX_LAST) && (cnt_q == CNT_LAST);
    assign phase     = (cnt_q < BLANK_END) ? PH_BLANK : PH_SHOW;

    bcd_to_seg u_dec (
        .bcd_i (cur_nib),
        .seg_o (dec_seg)
    );

    always_comb begin
        cnt_d        = cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        disp_d       = disp_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        ready_d      = ready_q;
        seg_d        = SEG_BLANK;
        en_d         = '0;

        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end

        if (load && ready_q) begin
            pend_d       = digits_in;
            pend_valid_d = 1'b1;
            ready_d      = 1'b0;
        end

        // ready is low whenever pend_valid is set, so this never collides with a load.
        if (frame_end && pend_valid_q) begin
            disp_d       = pend_q;
            pend_valid_d = 1'b0;
            ready_d      = 1'b1;
        end

        if (phase == PH_SHOW) begin
            en_d  = NUM_DIGITS'(1) << idx_q;
            seg_d = lz_blank ? SEG_BLANK : dec_seg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            disp_q       <= {NUM_DIGITS{4'hF}};
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            ready_q      <= 1'b1;
            seg_q        <= SEG_BLANK;
            en_q         <= '0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            ready_q      <= ready_d;
            seg_q        <= seg_d;
            en_q         <= en_d;
        end
    end

    assign ready    = ready_q;
    assign segment  = seg_q;
    assign digit_en = en_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl: table of loads with expected
// per-digit segment patterns, compared through a scoreboard after each frame swap.
module tb_seven_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = ND * DIV;

    typedef logic [ND-1:0][6:0] seg4_t;

    typedef struct packed {
        logic [15:0] digits;
        logic        lz;
        seg4_t       exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   digits_in = '0;
    logic          blank_lz = 1'b0;
    logic          ready;
    logic [6:0]    segment;
    logic [ND-1:0] digit_en;

    int    n_tests = 0;
    int    n_fail  = 0;
    seg4_t exp_q [$];
    vec_t  vecs [6];

    seven_seg_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (DIV),
        .BLANK_CYC   (BLANK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .digits_in (digits_in),
        .blank_lz  (blank_lz),
        .ready     (ready),
        .segment   (segment),
        .digit_en  (digit_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %0h", name, act);
        end
    endtask

    task automatic do_load(input logic [15:0] d, input seg4_t e);
        bit got = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ready) begin
                got = 1;
                break;
            end
        end
        chk("load_ready_wait", 32'(got), 32'd1);
        load      = 1'b1;
        digits_in = d;
        @(posedge clk);
        #1;
        load = 1'b0;
        chk($sformatf("ready_drop_%04h", d), 32'(ready), 32'd0);
        exp_q.push_back(e);
    endtask

    // Waits for the swap (ready rising), then watches one whole frame.
    task automatic observe_frame(input string tag);
        int         hi [ND];
        logic [6:0] seen [ND];
        int         viol;
        bit         got;
        seg4_t      e;
        got  = 0;
        viol = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (ready) begin
                got = 1;
                break;
            end
        end
        chk({tag, "_swap"}, 32'(got), 32'd1);
        if (!got) return;
        for (int d = 0; d < ND; d++) begin
            hi[d]   = 0;
            seen[d] = '0;
        end
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            if (digit_en == '0) begin
                if (segment != 7'd0) viol++;
            end else if ($onehot(digit_en)) begin
                for (int d = 0; d < ND; d++) begin
                    if (digit_en[d]) begin
                        if (hi[d] > 0 && seen[d] != segment) viol++;
                        seen[d] = segment;
                        hi[d]++;
                    end
                end
            end else begin
                viol++;
            end
        end
        chk({tag, "_glitch"}, 32'(viol), 32'd0);
        for (int d = 0; d < ND; d++)
            chk($sformatf("%s_on_cycles_d%0d", tag, d), 32'(hi[d]), 32'(DIV - BLANK));
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            for (int d = 0; d < ND; d++)
                chk($sformatf("%s_seg_d%0d", tag, d), 32'(seen[d]), 32'(e[d]));
        end
    endtask

    initial begin
        int nz;
        int rdy_low;
        bit got;

        vecs[0] = '{digits: 16'h1234, lz: 1'b0,
                    exp: {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011}};
        vecs[1] = '{digits: 16'h0050, lz: 1'b1,
                    exp: {7'b0000000, 7'b0000000, 7'b1011011, 7'b1111110}};
        vecs[2] = '{digits: 16'h0000, lz: 1'b1,
                    exp: {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}};
        vecs[3] = '{digits: 16'hA0F7, lz: 1'b1,
                    exp: {7'b0000000, 7'b1111110, 7'b0000000, 7'b1110000}};
        vecs[4] = '{digits: 16'h8765, lz: 1'b0,
                    exp: {7'b1111111, 7'b1110000, 7'b1011111, 7'b1011011}};
        vecs[5] = '{digits: 16'h0009, lz: 1'b0,
                    exp: {7'b1111110, 7'b1111110, 7'b1111110, 7'b1111011}};

        // Power-on reset and release timing.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_segment", 32'(segment), 32'd0);
        chk("rst_digit_en", 32'(digit_en), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("edge1_en", 32'(digit_en), 32'd0);
        @(posedge clk); #1;
        chk("edge2_en", 32'(digit_en), 32'd0);
        @(posedge clk); #1;
        chk("edge3_en", 32'(digit_en), 32'd1);
        nz = 0;
        for (int c = 0; c < FRAME - 3; c++) begin
            @(negedge clk);
            if (segment != 7'd0) nz++;
        end
        chk("first_frame_blank", 32'(nz), 32'd0);

        // Table of loads, each checked over the frame after its swap.
        for (int v = 0; v < 6; v++) begin
            blank_lz = vecs[v].lz;
            do_load(vecs[v].digits, vecs[v].exp);
            if (v == 0) begin
                @(negedge clk);
                load      = 1'b1;
                digits_in = 16'h9999;
                @(posedge clk); #1;
                load = 1'b0;
                chk("ignored_load_ready", 32'(ready), 32'd0);
            end
            observe_frame($sformatf("v%0d_%04h", v, vecs[v].digits));
            chk($sformatf("v%0d_ready_after", v), 32'(ready), 32'd1);
        end

        // Reset while a load is pending and a digit is lit.
        blank_lz = 1'b0;
        do_load(16'h4321, vecs[0].exp);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (digit_en != '0) begin
                got = 1;
                break;
            end
        end
        chk("pre_reset_lit", 32'(got), 32'd1);
        chk("pre_reset_pending", 32'(ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_segment", 32'(segment), 32'd0);
        chk("midrst_digit_en", 32'(digit_en), 32'd0);
        chk("midrst_ready", 32'(ready), 32'd1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nz      = 0;
        rdy_low = 0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            @(negedge clk);
            if (segment != 7'd0) nz++;
            if (!ready) rdy_low++;
        end
        chk("postrst_blank", 32'(nz), 32'd0);
        chk("postrst_ready_high", 32'(rdy_low), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
